// File: rtl/hash_pkg.sv
// Shared MurmurHash3 finaliser constants and width-dependent lookup helpers.
package hash_pkg;

  localparam logic [31:0] FMIX32_C1 = 32'h85eb_ca6b;
  localparam logic [31:0] FMIX32_C2 = 32'hc2b2_ae35;
  localparam logic [63:0] FMIX64_C1 = 64'hff51_afd7_ed55_8ccd;
  localparam logic [63:0] FMIX64_C2 = 64'hc4ce_b9fe_1a85_ec53;

  localparam int unsigned FMIX32_S1 = 16;
  localparam int unsigned FMIX32_S2 = 13;
  localparam int unsigned FMIX32_S3 = 16;
  localparam int unsigned FMIX64_S1 = 33;
  localparam int unsigned FMIX64_S2 = 33;
  localparam int unsigned FMIX64_S3 = 33;

  // Shift amount for xorshift round idx (1..3) at the given key width.
  function automatic int unsigned fmix_shift(input int unsigned key_width,
                                             input int unsigned idx);
    int unsigned s;
    s = 0;
    if (key_width == 64) begin
      case (idx)
        1: s = FMIX64_S1;
        2: s = FMIX64_S2;
        3: s = FMIX64_S3;
        default: s = 0;
      endcase
    end else begin
      case (idx)
        1: s = FMIX32_S1;
        2: s = FMIX32_S2;
        3: s = FMIX32_S3;
        default: s = 0;
      endcase
    end
    return s;
  endfunction

  // Multiplier constant for round idx (1..2), zero-extended to 64 bits.
  function automatic logic [63:0] fmix_const(input int unsigned key_width,
                                             input int unsigned idx);
    logic [63:0] c;
    c = '0;
    if (key_width == 64) begin
      case (idx)
        1: c = FMIX64_C1;
        2: c = FMIX64_C2;
        default: c = '0;
      endcase
    end else begin
      case (idx)
        1: c = {32'h0, FMIX32_C1};
        2: c = {32'h0, FMIX32_C2};
        default: c = '0;
      endcase
    end
    return c;
  endfunction

endpackage

// File: rtl/murmur_xorshift_mul.sv
// One finaliser round: registered xorshift, then registered mod-2^W multiply.
module murmur_xorshift_mul #(
  parameter int unsigned  W     = 32,
  parameter int unsigned  SHIFT = 16,
  parameter logic [W-1:0] MUL   = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] x_q;

  // Both stages advance together under the shared pipeline enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_q <= '0;
      q   <= '0;
    end else if (en) begin
      x_q <= d ^ (d >> SHIFT);
      q   <= x_q * MUL;
    end
  end

endmodule

// File: rtl/murmur_fmix_stream.sv
// Streaming MurmurHash3 fmix32/fmix64 finaliser, 6-cycle latency, global stall
// backpressure, with seed XOR on entry and a tag carried alongside each beat.
module murmur_fmix_stream
  import hash_pkg::*;
#(
  parameter int unsigned          KEY_WIDTH  = 32,
  parameter int unsigned          HASH_WIDTH = 32,
  parameter int unsigned          TAG_WIDTH  = 8,
  parameter logic [KEY_WIDTH-1:0] SEED       = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_valid,
  output logic                  i_ready,
  input  logic [KEY_WIDTH-1:0]  i_key,
  input  logic [TAG_WIDTH-1:0]  i_tag,
  output logic                  o_valid,
  input  logic                  o_ready,
  output logic [HASH_WIDTH-1:0] o_hash,
  output logic [TAG_WIDTH-1:0]  o_tag
);

  localparam int unsigned STAGES = 6;
  localparam int unsigned S1 = fmix_shift(KEY_WIDTH, 1);
  localparam int unsigned S2 = fmix_shift(KEY_WIDTH, 2);
  localparam int unsigned S3 = fmix_shift(KEY_WIDTH, 3);
  localparam logic [KEY_WIDTH-1:0] C1 = KEY_WIDTH'(fmix_const(KEY_WIDTH, 1));
  localparam logic [KEY_WIDTH-1:0] C2 = KEY_WIDTH'(fmix_const(KEY_WIDTH, 2));

  if (!(KEY_WIDTH == 32 || KEY_WIDTH == 64)) begin : g_bad_key_width
    $error("murmur_fmix_stream: KEY_WIDTH must be 32 or 64");
  end
  if (HASH_WIDTH < 1 || HASH_WIDTH > KEY_WIDTH) begin : g_bad_hash_width
    $error("murmur_fmix_stream: HASH_WIDTH must be in 1..KEY_WIDTH");
  end
  if (TAG_WIDTH < 1) begin : g_bad_tag_width
    $error("murmur_fmix_stream: TAG_WIDTH must be >= 1");
  end

  typedef struct packed {
    logic                 valid;
    logic [TAG_WIDTH-1:0] tag;
  } side_t;

  side_t [STAGES-1:0]    side_q;
  logic                  adv;
  logic [KEY_WIDTH-1:0]  m1;
  logic [KEY_WIDTH-1:0]  m2;
  logic [KEY_WIDTH-1:0]  x5_q;
  logic [HASH_WIDTH-1:0] hash_q;

  // The whole pipeline moves whenever the output slot is empty or being taken.
  assign adv     = o_ready | ~o_valid;
  assign i_ready = adv;

  murmur_xorshift_mul #(
    .W     (KEY_WIDTH),
    .SHIFT (S1),
    .MUL   (C1)
  ) u_round1 (
    .clk (clk),
    .rst (rst),
    .en  (adv),
    .d   (i_key ^ SEED),
    .q   (m1)
  );

  murmur_xorshift_mul #(
    .W     (KEY_WIDTH),
    .SHIFT (S2),
    .MUL   (C2)
  ) u_round2 (
    .clk (clk),
    .rst (rst),
    .en  (adv),
    .d   (m1),
    .q   (m2)
  );

  // Final xorshift, output register and the valid/tag chain that shadows the datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      side_q <= '0;
      x5_q   <= '0;
      hash_q <= '0;
    end else if (adv) begin
      side_q[0] <= '{valid: i_valid, tag: i_tag};
      for (int i = 1; i < STAGES; i++) begin
        side_q[i] <= side_q[i-1];
      end
      x5_q   <= m2 ^ (m2 >> S3);
      hash_q <= x5_q[HASH_WIDTH-1:0];
    end
  end

  if (HASH_WIDTH < KEY_WIDTH) begin : g_trunc
    logic unused_hash_hi;
    assign unused_hash_hi = ^x5_q[KEY_WIDTH-1:HASH_WIDTH];
  end

  assign o_valid = side_q[STAGES-1].valid;
  assign o_tag   = side_q[STAGES-1].tag;
  assign o_hash  = hash_q;

endmodule

// File: tb/tb_murmur_fmix_stream.sv
// Scoreboard bench: three finaliser instances (fmix32, fmix64, seeded/truncated fmix32)
// share one handshake stream and are checked against a C-style reference model.
module tb_murmur_fmix_stream;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid;
  logic        o_ready;
  logic [63:0] key;
  logic [7:0]  tag;

  logic        r32, v32, r64, v64, r16, v16;
  logic [31:0] h32;
  logic [63:0] h64;
  logic [15:0] h16;
  logic [7:0]  t32, t64, t16;

  always #5 clk = ~clk;

  murmur_fmix_stream #(.KEY_WIDTH(32), .HASH_WIDTH(32), .TAG_WIDTH(8), .SEED(32'h0)) u32 (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_ready(r32), .i_key(key[31:0]), .i_tag(tag),
    .o_valid(v32), .o_ready(o_ready), .o_hash(h32), .o_tag(t32));

  murmur_fmix_stream #(.KEY_WIDTH(64), .HASH_WIDTH(64), .TAG_WIDTH(8), .SEED(64'h0)) u64 (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_ready(r64), .i_key(key), .i_tag(tag),
    .o_valid(v64), .o_ready(o_ready), .o_hash(h64), .o_tag(t64));

  murmur_fmix_stream #(.KEY_WIDTH(32), .HASH_WIDTH(16), .TAG_WIDTH(8), .SEED(32'h1)) u16 (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_ready(r16), .i_key(key[31:0]), .i_tag(tag),
    .o_valid(v16), .o_ready(o_ready), .o_hash(h16), .o_tag(t16));

  typedef struct packed {
    logic [63:0] hash;
    logic [7:0]  tag;
  } exp_t;

  exp_t q32[$];
  exp_t q64[$];
  exp_t q16[$];

  int n_checks = 0;
  int n_fail   = 0;
  int n_acc    = 0;
  int n_del    = 0;

  logic        hold_chk = 1'b0;
  logic [63:0] hold_hash;
  logic [7:0]  hold_tag;

  function automatic logic [31:0] fmix32(input logic [31:0] h);
    h ^= h >> 16;
    h *= 32'h85ebca6b;
    h ^= h >> 13;
    h *= 32'hc2b2ae35;
    h ^= h >> 16;
    return h;
  endfunction

  function automatic logic [63:0] fmix64(input logic [63:0] k);
    k ^= k >> 33;
    k *= 64'hff51afd7ed558ccd;
    k ^= k >> 33;
    k *= 64'hc4ceb9fe1a85ec53;
    k ^= k >> 33;
    return k;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor and scoreboard: compare delivered beats, check stall stability, record accepts.
  always @(negedge clk) begin
    exp_t e;
    if (v32 && o_ready) begin
      if (q32.size() == 0) check("u32 unexpected o_valid", 64'(v32), 64'h0);
      else begin
        e = q32.pop_front();
        check("u32 hash", 64'(h32), e.hash);
        check("u32 tag", 64'(t32), 64'(e.tag));
      end
    end
    if (v64 && o_ready) begin
      n_del++;
      if (q64.size() == 0) check("u64 unexpected o_valid", 64'(v64), 64'h0);
      else begin
        e = q64.pop_front();
        check("u64 hash", h64, e.hash);
        check("u64 tag", 64'(t64), 64'(e.tag));
      end
    end
    if (v16 && o_ready) begin
      if (q16.size() == 0) check("u16 unexpected o_valid", 64'(v16), 64'h0);
      else begin
        e = q16.pop_front();
        check("u16 hash", 64'(h16), e.hash);
        check("u16 tag", 64'(t16), 64'(e.tag));
      end
    end
    if (hold_chk) begin
      check("stall o_valid", 64'(v64), 64'h1);
      check("stall o_hash", h64, hold_hash);
      check("stall o_tag", 64'(t64), 64'(hold_tag));
    end
    hold_chk  = v64 && !o_ready && !rst;
    hold_hash = h64;
    hold_tag  = t64;
    if (rst) begin
      q32.delete();
      q64.delete();
      q16.delete();
    end else if (i_valid && r64) begin
      q32.push_back('{hash: 64'(fmix32(key[31:0])), tag: tag});
      q64.push_back('{hash: fmix64(key), tag: tag});
      q16.push_back('{hash: 64'(fmix32(key[31:0] ^ 32'h1) & 32'h0000ffff), tag: tag});
      n_acc++;
    end
  end

  // Single beat into an empty pipe with o_ready=1; checks the exact 6-register latency.
  task automatic send_one(input logic [63:0] k, input logic [7:0] t);
    key = k; tag = t; i_valid = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check("latency o_valid", 64'(v64), 64'(c == 5));
    end
  endtask

  task automatic drain(input string name);
    i_valid = 1'b0;
    o_ready = 1'b1;
    for (int c = 0; c < 12 && (q64.size() + q32.size() + q16.size()) != 0; c++) begin
      @(posedge clk); #1;
    end
    check(name, 64'(q64.size() + q32.size() + q16.size()), 64'h0);
  endtask

  initial begin
    int start;
    int dstart;
    int cyc;
    logic [63:0] k;
    logic [63:0] first_hash;

    rst = 1'b1; i_valid = 1'b0; o_ready = 1'b1; key = '0; tag = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset o_valid", 64'(v64), 64'h0);
    check("reset o_hash", h64, 64'h0);
    check("reset o_tag", 64'(t64), 64'h0);
    check("reset i_ready", 64'(r64), 64'h1);
    @(posedge clk); #1;
    rst = 1'b0;

    // Known-answer vectors and seed cancellation.
    send_one(64'h1, 8'h11);
    check("fmix32(1)", 64'(h32), 64'h514e28b7);
    check("fmix32(1) tag", 64'(t32), 64'h11);
    @(posedge clk); #1;
    send_one(64'h0, 8'h22);
    check("fmix32(0)", 64'(h32), 64'h0);
    check("fmix64(0)", h64, 64'h0);
    @(posedge clk); #1;
    send_one(64'h1, 8'h33);
    check("seed cancels key", 64'(h16), 64'h0);
    @(posedge clk); #1;

    // 64 back-to-back beats must emerge contiguously.
    for (int c = 0; c < 70; c++) begin
      i_valid = (c < 64);
      key = {$urandom, $urandom};
      tag = 8'(c);
      @(negedge clk);
      check("contiguous o_valid", 64'(v64), 64'(c >= 6 && c <= 69));
      @(posedge clk); #1;
    end
    drain("b2b drain");

    // Random valid gaps and random backpressure.
    start = n_acc;
    cyc = 0;
    while (n_acc - start < 1000 && cyc < 20000) begin
      i_valid = ($urandom % 4) != 0;
      o_ready = $urandom % 2;
      key = {$urandom, $urandom};
      tag = 8'($urandom);
      @(posedge clk); #1;
      cyc++;
    end
    i_valid = 1'b0;
    check("random beats accepted", 64'(n_acc - start), 64'd1000);
    drain("random drain");

    // Fill with o_ready low, hold 20 cycles, then release.
    o_ready = 1'b0;
    i_valid = 1'b1;
    start = n_acc;
    for (int c = 0; c < 12; c++) begin
      key = {$urandom, $urandom};
      tag = 8'($urandom);
      @(negedge clk);
      if (!r64) break;
      @(posedge clk); #1;
    end
    check("fill accepted", 64'(n_acc - start), 64'd6);
    first_hash = h64;
    @(posedge clk); #1;
    for (int c = 0; c < 20; c++) begin
      key = {$urandom, $urandom};
      @(negedge clk);
      check("held i_ready", 64'(r64), 64'h0);
      check("held o_valid", 64'(v64), 64'h1);
      check("held o_hash", h64, first_hash);
      @(posedge clk); #1;
    end
    check("no accept while held", 64'(n_acc - start), 64'd6);
    dstart = n_del;
    drain("stall drain");
    check("stall drain count", 64'(n_del - dstart), 64'd6);

    // Reset with 4 beats in flight.
    @(posedge clk); #1;
    for (int c = 0; c < 4; c++) begin
      i_valid = 1'b1;
      key = {$urandom, $urandom};
      tag = 8'($urandom);
      @(posedge clk); #1;
    end
    i_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post-rst o_valid", 64'(v64), 64'h0);
    check("post-rst i_ready", 64'(r64), 64'h1);
    check("post-rst o_hash", h64, 64'h0);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      check("flushed o_valid", 64'(v64), 64'h0);
    end
    @(posedge clk); #1;
    k = {$urandom, $urandom};
    send_one(k, 8'h5a);
    check("post-rst fmix64", h64, fmix64(k));
    check("post-rst fmix32", 64'(h32), 64'(fmix32(k[31:0])));
    check("post-rst tag", 64'(t64), 64'h5a);
    @(posedge clk); #1;
    drain("final drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
